uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Message-atomic round-robin arbiter that shares the single `uart_tx` transmitter between up to N byte-stream requesters (heartbeat banner, debug dumps, command responses). It sits between the requesters and `uart_tx`. Each requester streams one message byte-by-byte with a valid/ready/last handshake. The arbiter paces each byte against the transmitter's `busy` signal and never interleaves bytes from different messages.

## Interface

- `N_REQ`, default 4: number of requesters, 1..8.
- `ABORT_CYCLES`, default 24'd1_200_000: stall limit in `LOAD` (100 ms at 12 MHz) before the grant is revoked.
- `IW`, derived: `(N_REQ>1) ? $clog2(N_REQ) : 1`. Not for override.

Ports (all outputs registered unless noted):

- `clk` in 1: 12 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: requester i presents a byte.
- `req_data` in 8*N_REQ: byte i at `[8i+7:8i]`.
- `req_last` in N_REQ: byte i is the final byte of its message.
- `req_ready` out N_REQ: combinational from registered state. Transfer occurs when `req_valid[i] && req_ready[i]`.
- `tx_data` out 8: to `uart_tx.data`. Reset 0.
- `tx_data_valid` out 1: one-cycle pulse to `uart_tx.data_valid`. Reset 0.
- `tx_busy` in 1: from `uart_tx.busy`.
- `grant_valid` out 1: a message is in progress. Reset 0.
- `grant_id` out IW: index of the current owner. Reset 0.
- `msg_done` out N_REQ: one-cycle pulse when requester i's last byte finishes transmitting. Reset 0.
- `msg_abort` out N_REQ: one-cycle pulse when requester i's grant is revoked by timeout. Reset 0.

## Operation

- States: `IDLE`, `LOAD`, `WAIT_HI`, `WAIT_LO`. Reset state is `IDLE`. Priority pointer `ptr` resets to 0.
- `IDLE`:
  - If any `req_valid` is high, select the first valid index searching upward from `ptr` with wrap-around.
  - Set `grant_id` to that index, set `grant_valid` to 1, clear the stall counter, and go to `LOAD`.
- `LOAD`:
  - `req_ready[grant_id]` is 1; all other bits of `req_ready` are 0.
  - On transfer: latch the byte into `tx_data`, latch `last`, assert `tx_data_valid` for one cycle, clear the stall counter, go to `WAIT_HI`.
  - With no transfer: increment the stall counter. At `ABORT_CYCLES-1`, pulse `msg_abort[grant_id]`, set `ptr` to `grant_id+1` mod N_REQ, clear `grant_valid`, and go to `IDLE`.
- `WAIT_HI`: wait for `tx_busy`=1, then go to `WAIT_LO`. No timeout.
- `WAIT_LO`: wait for `tx_busy`=0, then:
  - If the latched `last` is set: pulse `msg_done[grant_id]`, set `ptr` to `grant_id+1` mod N_REQ, clear `grant_valid`, and go to `IDLE`.
  - Otherwise: go to `LOAD`.
- `ptr` wrap: N_REQ-1 wraps to 0. With N_REQ=1, `ptr` stays 0.
- Non-granted requesters are never readied. Their `req_valid` may be held indefinitely.
- Requesters must keep `req_valid` and `req_data` stable until transfer. Mid-message gaps (`req_valid` low) are legal up to the abort limit.

## Timing

- Request to first `tx_data_valid`, when the requester's `req_valid` is already high in `IDLE`:
  - cycle 0: `IDLE`.
  - cycle 1: `LOAD`, transfer.
  - cycle 2: `tx_data_valid`=1.
- Byte-to-byte overhead is 2 cycles after `tx_busy` falls: `WAIT_LO` to `LOAD`, transfer, then `tx_data_valid`.
- `msg_done` and `msg_abort` assert for exactly one cycle. `grant_valid` falls in the same cycle.
- Simultaneous transfer and stall-limit in `LOAD`: the transfer wins and no abort occurs.
- A new arbitration can start in the cycle after release. The released requester has the lowest priority in that arbitration.
- `rst` assertion at any point immediately forces every output to its reset value, the state to `IDLE`, and `ptr` to 0. Any UART frame in flight is the transmitter's concern.

## Structure

- Shared header `uart_defs.vh`:
  - state encodings (2-bit);
  - `UART_CLK_HZ` = 12_000_000;
  - `UART_BAUD` = 115200;
  - ASCII constants (`ASCII_LF` = 8'h0A).
- Sub-module `rr_pick`: a combinational round-robin search of `req_valid` starting at `ptr`. Outputs `any` and `idx`.
- The arbiter holds the FSM, stall counter, latches and pulse generation.

## Test plan

- Single message: requester 0 sends 'H','I',LF with `last` on LF.
  - Exactly three `tx_data_valid` pulses with 8'h48, 8'h49, 8'h0A.
  - `msg_done[0]` pulses once, after the third `busy` fall.
- Contention: requesters 0 and 2 both valid from reset, 2-byte messages each.
  - Requester 0's message is sent completely, then requester 2's message.
  - Bytes are never interleaved.
  - `grant_id` sequence is 0 then 2.
- Fairness: requesters 0 and 1 continuously re-request. Grants alternate 0,1,0,1 over 8 messages.
- Abort: with `ABORT_CYCLES`=16, requester 1 sends one non-last byte and then drops `req_valid`.
  - `msg_abort[1]` pulses exactly 16 cycles after `LOAD` is entered.
  - Pending requester 2 is granted next.
- Boundary: `req_valid` rises in the same cycle the stall limit hits, so the byte is accepted and there is no abort.
- Reset mid-message: all outputs are 0 within the `rst` cycle. Arbitration restarts from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// UART timing constants and ASCII constants used by the message sources.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    localparam int UART_CLK_HZ = 12_000_000;
    localparam int UART_BAUD   = 115200;

    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin search: returns the first asserted bit of
// `valid`, scanning upward from `ptr` and wrapping past N_REQ-1 to 0.
// Ports:
//   valid [N_REQ]  request vector
//   ptr   [IW]     highest-priority index for this search
//   any            at least one request present
//   idx   [IW]     selected index (0 when `any` is low)
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    idx
);

    always_comb begin
        logic [IW:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit so ptr+k cannot overflow before the modulo wrap.
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!any && valid[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Message-atomic round-robin arbiter sharing one uart_tx between N_REQ
// byte-stream requesters. A granted requester keeps the transmitter until
// its `last` byte has been sent or it stalls for ABORT_CYCLES in LOAD.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_last [N]   per-requester handshake
//   req_data [8N]            byte i at [8i+7:8i]
//   req_ready [N]            decoded from registered state
//   tx_data, tx_data_valid   byte and one-cycle strobe to uart_tx
//   tx_busy                  uart_tx busy
//   grant_valid, grant_id    current owner
//   msg_done, msg_abort [N]  one-cycle completion / timeout pulses
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [23:0] ABORT_CYCLES = 24'd1_200_000,
    localparam int         IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_data_valid,
    input  logic               tx_busy,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_id,
    output logic [N_REQ-1:0]   msg_done,
    output logic [N_REQ-1:0]   msg_abort
);

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_data_valid_q, tx_data_valid_d;
    logic               last_q, last_d;
    logic [23:0]        stall_q, stall_d;
    logic [N_REQ-1:0]   msg_done_q, msg_done_d;
    logic [N_REQ-1:0]   msg_abort_q, msg_abort_d;

    logic               pick_any;
    logic [IW-1:0]      pick_idx;
    logic               xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Index after the releasing owner, so it has lowest priority next time.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (32'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    always_comb begin
        req_ready = '0;
        if (state_q == ST_LOAD) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign xfer = (state_q == ST_LOAD) && req_valid[grant_id_q];

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant_id_d      = grant_id_q;
        grant_valid_d   = grant_valid_q;
        tx_data_d       = tx_data_q;
        last_d          = last_q;
        stall_d         = stall_q;
        tx_data_valid_d = 1'b0;
        msg_done_d      = '0;
        msg_abort_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                    stall_d       = '0;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A transfer in the limit cycle takes precedence over abort.
                if (xfer) begin
                    tx_data_d       = req_data[{grant_id_q, 3'b000} +: 8];
                    last_d          = req_last[grant_id_q];
                    tx_data_valid_d = 1'b1;
                    stall_d         = '0;
                    state_d         = ST_WAIT_HI;
                end else if (stall_q == ABORT_CYCLES - 24'd1) begin
                    msg_abort_d[grant_id_q] = 1'b1;
                    ptr_d                   = next_idx(grant_id_q);
                    grant_valid_d           = 1'b0;
                    state_d                 = ST_IDLE;
                end else begin
                    stall_d = stall_q + 24'd1;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        msg_done_d[grant_id_q] = 1'b1;
                        ptr_d                  = next_idx(grant_id_q);
                        grant_valid_d          = 1'b0;
                        state_d                = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            grant_id_q      <= '0;
            grant_valid_q   <= 1'b0;
            tx_data_q       <= '0;
            tx_data_valid_q <= 1'b0;
            last_q          <= 1'b0;
            stall_q         <= '0;
            msg_done_q      <= '0;
            msg_abort_q     <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            grant_id_q      <= grant_id_d;
            grant_valid_q   <= grant_valid_d;
            tx_data_q       <= tx_data_d;
            tx_data_valid_q <= tx_data_valid_d;
            last_q          <= last_d;
            stall_q         <= stall_d;
            msg_done_q      <= msg_done_d;
            msg_abort_q     <= msg_abort_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_data_valid_q;
    assign grant_valid   = grant_valid_q;
    assign grant_id      = grant_id_q;
    assign msg_done      = msg_done_q;
    assign msg_abort     = msg_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Scoreboard bench: each scenario pushes its hand-derived event sequence
// (transmitted bytes, done and abort pulses) before driving requesters; a
// monitor pops and compares on every DUT output event.
module tb_uart_tx_arbiter;

    localparam int EV_TX    = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;
    localparam int TMO      = 3000;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_busy;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [3:0]  msg_done;
    logic [3:0]  msg_abort;

    logic        rv [4];
    logic        rl [4];
    logic [7:0]  rd [4];

    typedef struct {
        int         kind;
        int         id;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   load_cyc = 0;
    logic [3:0] prev_ready = '0;
    int   bcnt = 0;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .ABORT_CYCLES (24'd16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .msg_done      (msg_done),
        .msg_abort     (msg_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]      = rv[i];
            req_last[i]       = rl[i];
            req_data[8*i +: 8] = rd[i];
        end
    end

    // Transmitter model: busy for 5 cycles after each data strobe.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) bcnt = 0;
            else if (tx_data_valid) bcnt = 5;
            else if (bcnt > 0) bcnt = bcnt - 1;
            tx_busy = (bcnt > 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int id, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int id, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d id=%0d data=%0h, expected none", kind, id, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.id != id || (kind == EV_TX && e.data != data)) begin
                errors++;
                $display("FAIL event_at_cyc%0d: got kind=%0d id=%0d data=%0h expected kind=%0d id=%0d data=%0h",
                         cyc, kind, id, data, e.kind, e.id, e.data);
            end
        end
    endtask

    function automatic int low_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_ready = '0;
            end else begin
                if (req_ready != 0 && prev_ready == 0) load_cyc = cyc;
                prev_ready = req_ready;
                if (tx_data_valid) begin
                    pop_check(EV_TX, int'(grant_id), tx_data);
                    chk("grant_valid_at_tx", 32'(grant_valid), 32'd1);
                end
                if (msg_done != 0) begin
                    pop_check(EV_DONE, low_idx(msg_done), 8'h00);
                    chk("done_onehot", $countones(msg_done), 32'd1);
                    chk("grant_valid_at_done", 32'(grant_valid), 32'd0);
                    chk("busy_low_at_done", 32'(tx_busy), 32'd0);
                end
                if (msg_abort != 0) begin
                    pop_check(EV_ABORT, low_idx(msg_abort), 8'h00);
                    chk("abort_delay", 32'(cyc - load_cyc), 32'd16);
                    chk("grant_valid_at_abort", 32'(grant_valid), 32'd0);
                end
            end
        end
    endtask

    task automatic wait_xfer(input int i);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready[i] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_req%0d: got no ready, expected ready within %0d cycles", i, TMO);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input int i, input logic [31:0] bytes, input int n, input bit fin_last);
        for (int k = 0; k < n; k++) begin
            rd[i] = bytes[8*k +: 8];
            rl[i] = fin_last && (k == n - 1);
            rv[i] = 1'b1;
            wait_xfer(i);
        end
        rv[i] = 1'b0;
        rl[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_all();
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b0;
            rl[i] = 1'b0;
            rd[i] = 8'h00;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_grant", {29'd0, grant_valid, grant_id}, 32'd0);
        chk("rst_pulses", {24'd0, msg_done, msg_abort}, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        do_reset();

        // Single message "HI\n" from requester 0.
        push(EV_TX, 0, 8'h48);
        push(EV_TX, 0, 8'h49);
        push(EV_TX, 0, 8'h0A);
        push(EV_DONE, 0, 8'h00);
        send_msg(0, 32'h000A4948, 3, 1'b1);
        drain();

        // Contention: 0 and 2 from reset, whole messages, 0 first.
        do_reset();
        push(EV_TX, 0, 8'hA0);
        push(EV_TX, 0, 8'hA1);
        push(EV_DONE, 0, 8'h00);
        push(EV_TX, 2, 8'hB0);
        push(EV_TX, 2, 8'hB1);
        push(EV_DONE, 2, 8'h00);
        fork
            send_msg(0, 32'h0000A1A0, 2, 1'b1);
            send_msg(2, 32'h0000B1B0, 2, 1'b1);
        join
        drain();

        // Fairness: 0 and 1 re-request continuously; grants alternate.
        do_reset();
        for (int m = 0; m < 4; m++) begin
            push(EV_TX, 0, 8'h10 + 8'(m));
            push(EV_DONE, 0, 8'h00);
            push(EV_TX, 1, 8'h20 + 8'(m));
            push(EV_DONE, 1, 8'h00);
        end
        fork
            for (int m = 0; m < 4; m++) send_msg(0, 32'(8'h10 + 8'(m)), 1, 1'b1);
            for (int m = 0; m < 4; m++) send_msg(1, 32'(8'h20 + 8'(m)), 1, 1'b1);
        join
        drain();

        // Abort: requester 1 stalls after a non-last byte; 2 is next.
        do_reset();
        push(EV_TX, 1, 8'h55);
        push(EV_ABORT, 1, 8'h00);
        push(EV_TX, 2, 8'h77);
        push(EV_DONE, 2, 8'h00);
        fork
            send_msg(1, 32'h00000055, 1, 1'b0);
            send_msg(2, 32'h00000077, 1, 1'b1);
        join
        drain();

        // Boundary: byte arrives in the stall-limit cycle and is accepted.
        do_reset();
        push(EV_TX, 1, 8'hC1);
        push(EV_TX, 1, 8'hC2);
        push(EV_DONE, 1, 8'h00);
        send_msg(1, 32'h000000C1, 1, 1'b0);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!req_ready[1] && t < TMO) begin
                @(negedge clk);
                t++;
            end
            chk("boundary_load_seen", 32'(req_ready[1]), 32'd1);
            repeat (15) @(negedge clk);
            chk("boundary_still_ready", 32'(req_ready[1]), 32'd1);
            rd[1] = 8'hC2;
            rl[1] = 1'b1;
            rv[1] = 1'b1;
            @(posedge clk);
            #1;
            rv[1] = 1'b0;
            rl[1] = 1'b0;
        end
        drain();

        // Reset mid-message: ptr moved to 2, requester 3 owns the bus.
        do_reset();
        push(EV_TX, 1, 8'hD1);
        push(EV_DONE, 1, 8'h00);
        send_msg(1, 32'h000000D1, 1, 1'b1);
        drain();
        push(EV_TX, 3, 8'hE1);
        send_msg(3, 32'h000000E1, 1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_pulses", {24'd0, msg_done, msg_abort}, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(EV_TX, 0, 8'hF0);
        push(EV_DONE, 0, 8'h00);
        push(EV_TX, 2, 8'hF2);
        push(EV_DONE, 2, 8'h00);
        fork
            send_msg(0, 32'h000000F0, 1, 1'b1);
            send_msg(2, 32'h000000F2, 1, 1'b1);
        join
        drain();
    endtask

    initial begin
        fork
            monitor();
            begin
                run_all();
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join
    end

endmodule
